// File: rtl/blink_pattern_pkg.sv
// Shared definitions for the three-state LED signalling (off / blink / on).
// Both the pattern generator and the decoder import this so the codes agree.
package blink_pattern_pkg;

    typedef enum logic [1:0] {
        STATE_OFF     = 2'd0,
        STATE_BLINK   = 2'd1,
        STATE_ON      = 2'd2,
        STATE_UNKNOWN = 2'd3
    } led_state_t;

    localparam int          ACC_W   = 8;
    localparam logic [7:0]  ACC_MAX = 8'hFF;

    // Steady windows report the held level; a moderate toggle count is a blink,
    // anything else (too few to be a blink, or noise) is unknown.
    function automatic led_state_t classify_window(
        input logic [ACC_W-1:0] count,
        input logic             lvl,
        input logic [ACC_W-1:0] min_toggles,
        input logic [ACC_W-1:0] max_toggles
    );
        if (count == '0) begin
            return lvl ? STATE_ON : STATE_OFF;
        end
        if ((count >= min_toggles) && (count <= max_toggles)) begin
            return STATE_BLINK;
        end
        return STATE_UNKNOWN;
    endfunction

endpackage

// File: rtl/blink_state_decoder_input_sync.sv
// Pin synchroniser, edge-detect arming and optional glitch filter for the decoder.
// Optional: BLINK_DECODE_GLITCH_FILTER_EN adds a 4-cycle stability filter on the level.
module input_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic srst,
    input  logic sig_in,
    output logic lvl,
    output logic toggle
);

`ifdef BLINK_DECODE_GLITCH_FILTER_EN
    localparam int FILTER_DEPTH = 4;
`else
    localparam int FILTER_DEPTH = 0;
`endif
    // Arming covers the filter latency too, so a pin high at reset never edges.
    localparam int ARM_CYCLES = SYNC_STAGES + 1 + FILTER_DEPTH;
    localparam int ARM_W      = $clog2(ARM_CYCLES + 1);
    localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_CYCLES);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   raw_lvl;
    logic                   clean_lvl;
    logic                   prev_reg;
    logic [ARM_W-1:0]       arm_cnt_reg;
    logic                   armed;

    always_ff @(posedge clk) begin
        if (srst) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], sig_in};
        end
    end

    assign raw_lvl = sync_reg[SYNC_STAGES-1];

`ifdef BLINK_DECODE_GLITCH_FILTER_EN
    logic       filt_reg;
    logic [1:0] stable_cnt_reg;

    // A differing level must persist for FILTER_DEPTH consecutive edges.
    always_ff @(posedge clk) begin
        if (srst) begin
            filt_reg       <= 1'b0;
            stable_cnt_reg <= 2'd0;
        end else if (raw_lvl == filt_reg) begin
            stable_cnt_reg <= 2'd0;
        end else if (stable_cnt_reg == 2'(FILTER_DEPTH - 1)) begin
            filt_reg       <= raw_lvl;
            stable_cnt_reg <= 2'd0;
        end else begin
            stable_cnt_reg <= stable_cnt_reg + 2'd1;
        end
    end

    assign clean_lvl = filt_reg;
`else
    assign clean_lvl = raw_lvl;
`endif

    assign armed = (arm_cnt_reg == ARM_LAST);

    always_ff @(posedge clk) begin
        if (srst) begin
            arm_cnt_reg <= '0;
            prev_reg    <= 1'b0;
        end else begin
            if (!armed) begin
                arm_cnt_reg <= arm_cnt_reg + ARM_W'(1);
            end
            prev_reg <= clean_lvl;
        end
    end

    assign lvl    = clean_lvl;
    assign toggle = armed && (clean_lvl != prev_reg);

endmodule

// File: rtl/blink_state_decoder.sv
// Receive side of the off/blink/on LED signalling: counts toggles per window and classifies.
// Optional: BLINK_DECODE_GLITCH_FILTER_EN (glitch filter inside input_sync).
module blink_state_decoder
    import blink_pattern_pkg::*;
#(
    parameter int WINDOW_CYCLES = 1 << 24,
    parameter int MIN_TOGGLES   = 2,
    parameter int MAX_TOGGLES   = 16,
    parameter int SYNC_STAGES   = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       SIG_IN,
    output logic [1:0] STATE,
    output logic       STATE_VALID,
    output logic       STATE_CHANGE,
    output logic [7:0] TOGGLE_COUNT
);

    localparam int                WCNT_W   = $clog2(WINDOW_CYCLES);
    localparam logic [WCNT_W-1:0] WIN_LAST = WCNT_W'(WINDOW_CYCLES - 1);
    localparam logic [ACC_W-1:0]  MIN_T    = ACC_W'(MIN_TOGGLES);
    localparam logic [ACC_W-1:0]  MAX_T    = ACC_W'(MAX_TOGGLES);

    logic              lvl;
    logic              toggle;
    logic [WCNT_W-1:0] wcnt_reg;
    logic [ACC_W-1:0]  acc_reg;
    logic [ACC_W-1:0]  acc_next;
    logic              window_end;
    led_state_t        state_reg;
    led_state_t        state_next;
    logic              valid_reg;
    logic              change_reg;
    logic [ACC_W-1:0]  count_reg;

    input_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_input_sync (
        .clk   (CLK),
        .srst  (RST),
        .sig_in(SIG_IN),
        .lvl   (lvl),
        .toggle(toggle)
    );

    // The window-end cycle's own toggle belongs to the closing window.
    always_comb begin
        acc_next = acc_reg;
        if (toggle && (acc_reg != ACC_MAX)) begin
            acc_next = acc_reg + 8'd1;
        end
    end

    assign window_end = (wcnt_reg == WIN_LAST);
    assign state_next = classify_window(acc_next, lvl, MIN_T, MAX_T);

    always_ff @(posedge CLK) begin
        if (RST) begin
            wcnt_reg   <= '0;
            acc_reg    <= '0;
            state_reg  <= STATE_OFF;
            valid_reg  <= 1'b0;
            change_reg <= 1'b0;
            count_reg  <= '0;
        end else if (window_end) begin
            wcnt_reg   <= '0;
            acc_reg    <= '0;
            state_reg  <= state_next;
            count_reg  <= acc_next;
            valid_reg  <= 1'b1;
            change_reg <= valid_reg && (state_next != state_reg);
        end else begin
            wcnt_reg   <= wcnt_reg + WCNT_W'(1);
            acc_reg    <= acc_next;
            change_reg <= 1'b0;
        end
    end

    assign STATE        = state_reg;
    assign STATE_VALID  = valid_reg;
    assign STATE_CHANGE = change_reg;
    assign TOGGLE_COUNT = count_reg;

endmodule

// File: tb/tb_blink_state_decoder.sv
// Directed self-checking bench for blink_state_decoder (16-cycle windows, plus a 512-cycle
// instance for accumulator saturation). Filter scenario runs when BLINK_DECODE_GLITCH_FILTER_EN is set.
module tb_blink_state_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sig = 1'b0;
    logic [1:0] state;
    logic       valid;
    logic       change;
    logic [7:0] tc;

    logic       sat_rst = 1'b1;
    logic       sat_sig = 1'b0;
    logic [1:0] sat_state;
    logic       sat_valid;
    logic       sat_change;
    logic [7:0] sat_tc;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses   = 0;

    always #5 clk = ~clk;

    blink_state_decoder #(
        .WINDOW_CYCLES(16), .MIN_TOGGLES(2), .MAX_TOGGLES(8), .SYNC_STAGES(2)
    ) dut (
        .CLK(clk), .RST(rst), .SIG_IN(sig), .STATE(state),
        .STATE_VALID(valid), .STATE_CHANGE(change), .TOGGLE_COUNT(tc)
    );

    blink_state_decoder #(
        .WINDOW_CYCLES(512), .MIN_TOGGLES(2), .MAX_TOGGLES(8), .SYNC_STAGES(2)
    ) u_sat (
        .CLK(clk), .RST(sat_rst), .SIG_IN(sat_sig), .STATE(sat_state),
        .STATE_VALID(sat_valid), .STATE_CHANGE(sat_change), .TOGGLE_COUNT(sat_tc)
    );

    task automatic tick;
        @(posedge clk);
        #1;
        if (change) pulses++;
    endtask

    // Leaves the bench 1 time unit after the last reset edge with RST low.
    task automatic do_reset(input logic level);
        rst = 1'b1;
        sig = level;
        tick();
        tick();
        rst = 1'b0;
        pulses = 0;
    endtask

    task automatic test_reset;
        do_reset(1'b0);
        $display("test_reset: state=%0d valid=%0b change=%0b tc=%0d", state, valid, change, tc);
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", valid); end
        n_checks++; if (change !== 1'b0) begin n_fail++; $display("FAIL reset_change: got %0b want 0", change); end
        n_checks++; if (tc !== 8'd0) begin n_fail++; $display("FAIL reset_tc: got %0d want 0", tc); end
    endtask

    task automatic test_off;
        do_reset(1'b0);
        for (int c = 0; c < 15; c++) tick();
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL off_valid_early: got %0b want 0", valid); end
        tick();
        $display("test_off window 0: state=%0d valid=%0b tc=%0d", state, valid, tc);
        n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL off_valid: got %0b want 1", valid); end
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL off_state: got %0d want 0", state); end
        for (int c = 0; c < 32; c++) tick();
        $display("test_off window 2: state=%0d tc=%0d pulses=%0d", state, tc, pulses);
        n_checks++; if (tc !== 8'd0) begin n_fail++; $display("FAIL off_tc: got %0d want 0", tc); end
        n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL off_pulses: got %0d want 0", pulses); end
    endtask

    task automatic test_high_at_reset;
        do_reset(1'b1);
        for (int c = 0; c < 16; c++) tick();
        $display("test_high_at_reset: state=%0d tc=%0d change=%0b", state, tc, change);
        n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL high_state: got %0d want 2", state); end
        n_checks++; if (tc !== 8'd0) begin n_fail++; $display("FAIL high_tc: got %0d want 0", tc); end
        n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL high_pulses: got %0d want 0", pulses); end
    endtask

    task automatic test_blink;
        do_reset(1'b0);
        for (int c = 0; c < 16; c++) tick();
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL blink_first_state: got %0d want 0", state); end
        for (int w = 0; w < 3; w++) begin
            for (int c = 0; c < 16; c++) begin
                if (c % 4 == 0) sig = ~sig;
                tick();
            end
            $display("test_blink window %0d: state=%0d tc=%0d change=%0b", w + 1, state, tc, change);
            n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL blink_state: got %0d want 1", state); end
            n_checks++; if (tc !== 8'd4) begin n_fail++; $display("FAIL blink_tc: got %0d want 4", tc); end
            n_checks++;
            if (change !== (w == 0)) begin
                n_fail++; $display("FAIL blink_change: got %0b want %0b", change, (w == 0));
            end
        end
        n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL blink_pulses: got %0d want 1", pulses); end
    endtask

    task automatic test_fast_toggle;
        do_reset(1'b0);
        for (int c = 0; c < 16; c++) begin sig = ~sig; tick(); end
        $display("test_fast_toggle window 0: state=%0d tc=%0d", state, tc);
        n_checks++; if (tc !== 8'd13) begin n_fail++; $display("FAIL fast_arm_tc: got %0d want 13", tc); end
        for (int c = 0; c < 16; c++) begin sig = ~sig; tick(); end
        $display("test_fast_toggle window 1: state=%0d tc=%0d", state, tc);
        n_checks++; if (tc !== 8'd16) begin n_fail++; $display("FAIL fast_tc: got %0d want 16", tc); end
        n_checks++; if (state !== 2'd3) begin n_fail++; $display("FAIL fast_state: got %0d want 3", state); end
        sig = 1'b0;
    endtask

    task automatic test_saturate;
        sat_rst = 1'b1;
        tick();
        tick();
        sat_rst = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            sat_sig = ~sat_sig;
            tick();
            if (i == 511) begin
                $display("test_saturate window 0: state=%0d tc=%0d", sat_state, sat_tc);
                n_checks++; if (sat_tc !== 8'd255) begin n_fail++; $display("FAIL sat_tc0: got %0d want 255", sat_tc); end
            end
        end
        $display("test_saturate window 1: state=%0d tc=%0d valid=%0b", sat_state, sat_tc, sat_valid);
        n_checks++; if (sat_tc !== 8'd255) begin n_fail++; $display("FAIL sat_tc1: got %0d want 255", sat_tc); end
        n_checks++; if (sat_state !== 2'd3) begin n_fail++; $display("FAIL sat_state: got %0d want 3", sat_state); end
        n_checks++; if (sat_change !== 1'b0) begin n_fail++; $display("FAIL sat_change: got %0b want 0", sat_change); end
    endtask

    task automatic test_state_sequence;
        do_reset(1'b1);
        for (int c = 0; c < 16; c++) tick();
        $display("test_state_sequence window 0: state=%0d tc=%0d", state, tc);
        n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL seq_on: got %0d want 2", state); end
        for (int c = 0; c < 16; c++) begin
            if (c == 5) sig = 1'b0;
            tick();
        end
        $display("test_state_sequence window 1: state=%0d tc=%0d change=%0b", state, tc, change);
        n_checks++; if (state !== 2'd3) begin n_fail++; $display("FAIL seq_unknown: got %0d want 3", state); end
        n_checks++; if (tc !== 8'd1) begin n_fail++; $display("FAIL seq_tc: got %0d want 1", tc); end
        n_checks++; if (change !== 1'b1) begin n_fail++; $display("FAIL seq_change1: got %0b want 1", change); end
        for (int c = 0; c < 16; c++) tick();
        $display("test_state_sequence window 2: state=%0d tc=%0d change=%0b", state, tc, change);
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL seq_off: got %0d want 0", state); end
        n_checks++; if (change !== 1'b1) begin n_fail++; $display("FAIL seq_change2: got %0b want 1", change); end
        n_checks++; if (pulses !== 2) begin n_fail++; $display("FAIL seq_pulses: got %0d want 2", pulses); end
    endtask

    task automatic test_mid_reset;
        do_reset(1'b0);
        for (int c = 0; c < 16; c++) tick();
        for (int c = 0; c < 16; c++) begin
            if (c % 4 == 0) sig = ~sig;
            tick();
        end
        n_checks++; if (tc !== 8'd4) begin n_fail++; $display("FAIL mid_pre_tc: got %0d want 4", tc); end
        for (int c = 0; c < 9; c++) begin
            if (c % 4 == 0) sig = ~sig;
            tick();
        end
        rst = 1'b1;
        tick();
        $display("test_mid_reset: state=%0d valid=%0b change=%0b tc=%0d", state, valid, change, tc);
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL mid_state: got %0d want 0", state); end
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %0b want 0", valid); end
        n_checks++; if (tc !== 8'd0) begin n_fail++; $display("FAIL mid_tc: got %0d want 0", tc); end
        rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 15; c++) tick();
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid_early: got %0b want 0", valid); end
        tick();
        $display("test_mid_reset window 0: state=%0d valid=%0b tc=%0d", state, valid, tc);
        n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL mid_valid_after: got %0b want 1", valid); end
        n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL mid_state_after: got %0d want 2", state); end
        n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL mid_pulses: got %0d want 0", pulses); end
    endtask

`ifdef BLINK_DECODE_GLITCH_FILTER_EN
    task automatic test_filter;
        do_reset(1'b0);
        for (int c = 0; c < 16; c++) tick();
        for (int c = 0; c < 16; c++) begin
            if (c == 2) sig = 1'b1;
            if (c == 4) sig = 1'b0;
            tick();
        end
        $display("test_filter short pulse: state=%0d tc=%0d", state, tc);
        n_checks++; if (tc !== 8'd0) begin n_fail++; $display("FAIL filt_short_tc: got %0d want 0", tc); end
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL filt_short_state: got %0d want 0", state); end
        for (int c = 0; c < 16; c++) begin
            if (c == 2) sig = 1'b1;
            if (c == 8) sig = 1'b0;
            tick();
        end
        $display("test_filter long pulse: state=%0d tc=%0d", state, tc);
        n_checks++; if (tc !== 8'd2) begin n_fail++; $display("FAIL filt_long_tc: got %0d want 2", tc); end
        n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL filt_long_state: got %0d want 1", state); end
    endtask
`endif

    initial begin
        test_reset();
`ifdef BLINK_DECODE_GLITCH_FILTER_EN
        test_filter();
`else
        test_off();
        test_high_at_reset();
        test_blink();
        test_fast_toggle();
        test_state_sequence();
        test_mid_reset();
`endif
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
